// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared types and helpers for the data-memory responder.
//   - MEM_SIZE_* : access size encodings driven by the MEM stage
//   - dmem_state_e : responder FSM states (IDLE -> WAIT -> RESP)
//   - lane_enables / replicate_lanes / extract_lane : byte-lane helpers
//   - misaligned / align_offset : alignment helpers used depending on
//     whether DMEM_MISALIGN_CHECK_EN is defined
package dmem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'b00,
    DMEM_ST_WAIT = 2'b01,
    DMEM_ST_RESP = 2'b10
  } dmem_state_e;

  // Byte enables for a store; unknown size encodings behave like a word.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      MEM_SIZE_BYTE: be = 4'b0001 << offset;
      MEM_SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; copy it into every lane so the byte
  // enables alone pick the destination.
  function automatic logic [31:0] replicate_lanes(input logic [1:0]  size,
                                                  input logic [31:0] data);
    logic [31:0] r;
    case (size)
      MEM_SIZE_BYTE: r = {4{data[7:0]}};
      MEM_SIZE_HALF: r = {2{data[15:0]}};
      default:       r = data;
    endcase
    return r;
  endfunction

  // Pull the addressed lane out of a RAM word and sign/zero extend it.
  function automatic logic [31:0] extract_lane(input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        is_unsigned,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_SIZE_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      MEM_SIZE_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      default:       r = word;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic m;
    case (size)
      MEM_SIZE_BYTE: m = 1'b0;
      MEM_SIZE_HALF: m = offset[0];
      default:       m = (offset != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [1:0] o;
    case (size)
      MEM_SIZE_BYTE: o = offset;
      MEM_SIZE_HALF: o = {offset[1], 1'b0};
      default:       o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// dmem_ram
//   Single-port synchronous RAM, 2**ADDR_WIDTH x 32-bit words, per-byte
//   write enables and a registered read port (old data on a same-cycle write).
//   Ports:
//     clk        in   clock
//     addr       in   word index
//     byte_en    in   per-lane write enables (0000 = read only)
//     write_data in   lane-replicated store data
//     read_data  out  registered word read from addr
module dmem_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            byte_en,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  // Contents are deliberately not reset; only the enabled lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        mem[addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
    read_data <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   MEM-stage data-memory responder for the mips pipeline. Accepts one
//   load/store at a time, models LATENCY cycles of access time and holds
//   o_stall until the one-cycle o_ready pulse.
//   Parameters: ADDR_WIDTH (word-index bits), LATENCY (1..15).
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     i_mem_read/i_mem_write  request kind, held until o_ready
//     i_addr                  byte address (upper bits wrap)
//     i_write_data            right-aligned store data
//     i_size, i_unsigned      access size, zero-extend select for loads
//     o_read_data             extended load data while o_ready=1, else 0
//     o_ready                 completion pulse
//     o_stall                 pipeline freeze request
//     o_addr_error            misalignment flag
//   Build option: DMEM_MISALIGN_CHECK_EN flags misaligned accesses; without
//   it they are silently aligned down and o_addr_error is tied 0.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_stall,
  output logic        o_addr_error
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e           state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_index;
  logic [1:0]            lat_offset;
  logic [1:0]            lat_size;
  logic [31:0]           lat_data;
  logic                  lat_write;
  logic                  lat_unsigned;
  logic                  lat_error;

  logic                  req;
  logic [1:0]            in_offset;
  logic                  in_error;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_bits;

  assign req     = i_mem_read | i_mem_write;
  assign o_stall = req & ~o_ready;

  assign unused_addr_bits = ^i_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign in_error     = misaligned(i_size, i_addr[1:0]);
  assign in_offset    = i_addr[1:0];
  assign o_addr_error = o_ready & lat_error;
`else
  assign in_error     = 1'b0;
  assign in_offset    = align_offset(i_size, i_addr[1:0]);
  assign o_addr_error = 1'b0;
`endif

  // The request is latched on acceptance; WAIT counts down the remaining
  // latency, a dropped request in WAIT is a pipeline flush, and RESP pulses
  // o_ready for exactly one cycle before returning to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DMEM_ST_IDLE;
      cnt          <= 4'd0;
      o_ready      <= 1'b0;
      lat_index    <= '0;
      lat_offset   <= 2'b00;
      lat_size     <= MEM_SIZE_BYTE;
      lat_data     <= 32'd0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_error    <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        DMEM_ST_IDLE: begin
          if (req) begin
            lat_index    <= i_addr[ADDR_WIDTH+1:2];
            lat_offset   <= in_offset;
            lat_size     <= i_size;
            lat_data     <= i_write_data;
            lat_write    <= i_mem_write;
            lat_unsigned <= i_unsigned;
            lat_error    <= in_error;
            cnt          <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              state   <= DMEM_ST_RESP;
              o_ready <= 1'b1;
            end else begin
              state <= DMEM_ST_WAIT;
            end
          end
        end
        DMEM_ST_WAIT: begin
          if (!req) begin
            state <= DMEM_ST_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state   <= DMEM_ST_RESP;
            o_ready <= 1'b1;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DMEM_ST_RESP: begin
          state <= DMEM_ST_IDLE;
        end
        default: begin
          state <= DMEM_ST_IDLE;
        end
      endcase
    end
  end

  // In IDLE the RAM reads straight from the incoming address so a
  // single-cycle latency still has data ready in RESP; afterwards the
  // latched index is used, and the store commits on the RESP edge.
  always_comb begin
    ram_addr = lat_index;
    ram_be   = 4'b0000;
    if (state == DMEM_ST_IDLE) begin
      ram_addr = i_addr[ADDR_WIDTH+1:2];
    end
    if (state == DMEM_ST_RESP && lat_write && !lat_error) begin
      ram_be = lane_enables(lat_size, lat_offset);
    end
  end

  assign ram_wdata = replicate_lanes(lat_size, lat_data);

  // Stores (including the illegal read+write case) and flagged accesses
  // return zero.
  assign o_read_data = (o_ready && !lat_write && !lat_error)
                       ? extract_lane(lat_size, lat_offset, lat_unsigned, ram_rdata)
                       : 32'd0;

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk        (clk),
    .addr       (ram_addr),
    .byte_en    (ram_be),
    .write_data (ram_wdata),
    .read_data  (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW     = 8;
  localparam int LAT0   = 2;
  localparam int LAT1   = 1;
  localparam int NBYTES = 4 << AW;
  localparam int BOUND  = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  size  [2];
  logic        uns   [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        stall [2];
  logic        aerr  [2];

  int checks;
  int failures;

  logic [7:0] ref_mem [2][NBYTES];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [21];

  always #5 clk = ~clk;

  // Instance 0 runs the default two-cycle latency, instance 1 the
  // single-cycle back-to-back case.
  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset),
    .i_mem_read(rd[0]), .i_mem_write(wr[0]), .i_addr(addr[0]),
    .i_write_data(wdata[0]), .i_size(size[0]), .i_unsigned(uns[0]),
    .o_read_data(rdata[0]), .o_ready(ready[0]), .o_stall(stall[0]),
    .o_addr_error(aerr[0])
  );

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .i_mem_read(rd[1]), .i_mem_write(wr[1]), .i_addr(addr[1]),
    .i_write_data(wdata[1]), .i_size(size[1]), .i_unsigned(uns[1]),
    .o_read_data(rdata[1]), .o_ready(ready[1]), .o_stall(stall[1]),
    .o_addr_error(aerr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 0) ? LAT0 : LAT1;
  endfunction

  // Byte-array memory model: misaligned accesses are flagged or rounded
  // down, loads are assembled little-endian and extended arithmetically.
  task automatic model_access(input int sel, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic u,
                              output logic [31:0] data, output logic err);
    int base;
    int off;
    int n;
    logic [31:0] val;
    base = int'(a[AW+1:2]) * 4;
    off  = int'(a[1:0]);
    n    = (sz == MEM_SIZE_BYTE) ? 1 : (sz == MEM_SIZE_HALF) ? 2 : 4;
    data = 32'd0;
    err  = 1'b0;
    if (off % n != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      err = 1'b1;
      return;
`else
      off = off - (off % n);
`endif
    end
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[sel][base + off + i] = d[8*i +: 8];
    end else if (r) begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val = val | (32'(ref_mem[sel][base + off + i]) << (8 * i));
      if (n < 4 && !u && val[8*n-1]) val = val | (32'hFFFFFFFF << (8 * n));
      data = val;
    end
  endtask

  // Drives one request on the next cycle, holds it until o_ready (bounded),
  // then drops it in the response cycle.
  task automatic applyStimulus(input int sel, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input logic u,
                               output logic [31:0] got_d, output logic got_e,
                               output int lat, output int stall_n);
    @(posedge clk); #1;
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d;
    size[sel] = sz; uns[sel] = u;
    lat = 0;
    stall_n = 0;
    #1;
    if (stall[sel]) stall_n++;
    while (lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
      if (ready[sel]) break;
      if (stall[sel]) stall_n++;
    end
    got_d = rdata[sel];
    got_e = aerr[sel];
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
  endtask

  task automatic do_access(input int sel, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic u,
                           input string tag, output logic [31:0] got);
    logic [31:0] exp_d;
    logic exp_e;
    logic got_e;
    int lat;
    int stall_n;
    applyStimulus(sel, r, w, a, d, sz, u, got, got_e, lat, stall_n);
    model_access(sel, r, w, a, d, sz, u, exp_d, exp_e);
    checkOutput({tag, "_latency"}, lat, lat_of(sel));
    checkOutput({tag, "_stall_cycles"}, stall_n, lat_of(sel));
    checkOutput({tag, "_addr_error"}, {31'd0, got_e}, {31'd0, exp_e});
    if (r || exp_e) checkOutput({tag, "_data"}, got, exp_d);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int kind;
    logic [31:0] ra;
    logic [1:0]  rs;

    checks = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MEM_SIZE_WORD, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,       MEM_SIZE_WORD, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h20, 32'h11223344, MEM_SIZE_WORD, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h21, 32'h80,       MEM_SIZE_BYTE, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h21, 32'h0,        MEM_SIZE_BYTE, 1'b0, 1'b1, 32'hFFFFFF80};
    vecs[5]  = '{1'b1, 1'b0, 32'h21, 32'h0,        MEM_SIZE_BYTE, 1'b1, 1'b1, 32'h00000080};
    vecs[6]  = '{1'b1, 1'b0, 32'h20, 32'h0,        MEM_SIZE_WORD, 1'b0, 1'b1, 32'h11228044};
    vecs[7]  = '{1'b0, 1'b1, 32'h30, 32'hAABBCCDD, MEM_SIZE_WORD, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h32, 32'h1234,     MEM_SIZE_HALF, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h32, 32'h0,        MEM_SIZE_HALF, 1'b0, 1'b1, 32'h00001234};
    vecs[10] = '{1'b1, 1'b0, 32'h30, 32'h0,        MEM_SIZE_WORD, 1'b0, 1'b1, 32'h1234CCDD};
    vecs[11] = '{1'b0, 1'b1, 32'h30, 32'h8001,     MEM_SIZE_HALF, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h30, 32'h0,        MEM_SIZE_HALF, 1'b0, 1'b1, 32'hFFFF8001};
    vecs[13] = '{1'b1, 1'b0, 32'h30, 32'h0,        MEM_SIZE_HALF, 1'b1, 1'b1, 32'h00008001};
    vecs[14] = '{1'b1, 1'b1, 32'h50, 32'h55,       MEM_SIZE_WORD, 1'b0, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h50, 32'h0,        MEM_SIZE_WORD, 1'b0, 1'b1, 32'h00000055};
    vecs[16] = '{1'b0, 1'b1, 32'h53, 32'hFFFFFFA5, MEM_SIZE_BYTE, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 32'h50, 32'h0,        MEM_SIZE_WORD, 1'b0, 1'b1, 32'hA5000055};
    vecs[18] = '{1'b1, 1'b0, 32'h53, 32'h0,        MEM_SIZE_BYTE, 1'b0, 1'b1, 32'hFFFFFFA5};
    vecs[19] = '{1'b1, 1'b0, 32'h22, 32'h0,        MEM_SIZE_BYTE, 1'b1, 1'b1, 32'h00000022};
    vecs[20] = '{1'b1, 1'b0, 32'h30, 32'h0,        MEM_SIZE_WORD, 1'b1, 1'b1, 32'h12348001};

    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
      size[s] = MEM_SIZE_WORD; uns[s] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset_ready%0d", s), {31'd0, ready[s]}, 32'd0);
      checkOutput($sformatf("reset_rdata%0d", s), rdata[s], 32'd0);
      checkOutput($sformatf("reset_aerr%0d", s), {31'd0, aerr[s]}, 32'd0);
      checkOutput($sformatf("reset_stall%0d", s), {31'd0, stall[s]}, 32'd0);
    end

    // Give every word a known value so later loads are predictable.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < (1 << AW); w++)
        do_access(s, 1'b0, 1'b1, 32'(w * 4), $urandom, MEM_SIZE_WORD, 1'b0, "fill", got);

    for (int i = 0; i < 21; i++) begin
      do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].size, vecs[i].uns, $sformatf("vec%0d", i), got);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d_const", i), got, vecs[i].exp);
    end

    @(posedge clk); #1;
    checkOutput("ready_single_pulse", {31'd0, ready[0]}, 32'd0);

    // Flushed store must leave memory untouched and never complete.
    do_access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, MEM_SIZE_WORD, 1'b0, "abort_pre", got);
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hFFFFFFFF; size[0] = MEM_SIZE_WORD;
    @(posedge clk); #1;
    checkOutput("abort_wait_ready", {31'd0, ready[0]}, 32'd0);
    wr[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort_no_ready", {31'd0, ready[0]}, 32'd0);
    end
    do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, MEM_SIZE_WORD, 1'b0, "abort_post", got);
    checkOutput("abort_post_const", got, 32'h12345678);

    // Reset while a store waits discards it.
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h0; size[0] = MEM_SIZE_WORD;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr[0] = 1'b0;
    checkOutput("rst_wait_ready", {31'd0, ready[0]}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rst_no_ready", {31'd0, ready[0]}, 32'd0);
    end
    do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, MEM_SIZE_WORD, 1'b0, "rst_post", got);
    checkOutput("rst_post_const", got, 32'h12345678);

    // Address wrap plus misalignment.
    do_access(0, 1'b1, 1'b0, 32'h403, 32'h0, MEM_SIZE_WORD, 1'b0, "wrap_lw", got);
`ifdef DMEM_MISALIGN_CHECK_EN
    checkOutput("wrap_lw_const", got, 32'd0);
`endif
    do_access(0, 1'b0, 1'b1, 32'h45, 32'hBEEF, MEM_SIZE_HALF, 1'b0, "mis_sh", got);
    do_access(0, 1'b1, 1'b0, 32'h44, 32'h0, MEM_SIZE_WORD, 1'b0, "mis_lw", got);

    // Single-cycle latency, store/load alternating every other cycle.
    for (int i = 0; i < 6; i++) begin
      do_access(1, 1'b0, 1'b1, 32'(32'h80 + 4 * i), 32'(32'h10000000 + i), MEM_SIZE_WORD, 1'b0, "b2b_sw", got);
      do_access(1, 1'b1, 1'b0, 32'(32'h80 + 4 * i), 32'h0, MEM_SIZE_WORD, 1'b0, "b2b_lw", got);
      checkOutput($sformatf("b2b_const%0d", i), got, 32'(32'h10000000 + i));
    end

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 200; n++) begin
        kind = $urandom_range(0, 9);
        ra = $urandom;
        if ($urandom_range(0, 3) != 0) ra = ra & 32'h0000007F;
        rs = 2'($urandom_range(0, 2));
        do_access(s, kind < 5 || kind == 9, kind >= 5, ra, $urandom, rs,
                  1'($urandom_range(0, 1)), $sformatf("rand%0d", s), got);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
